// File: rtl/parity_pkg.sv
// Shared types and defaults for the serial even-parity receive path.
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_e;

    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 8;

    // Bit index width; DATA_W is at least 2 so this is never zero.
    function automatic int idx_w(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/parity_shift_accum.sv
// Deserialiser core: LSB-first shift register, running XOR and bit index.
module parity_shift_accum
    import parity_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic              bit_in,
    output logic [DATA_W-1:0] shreg,
    output logic              acc,
    output logic              last
);

    localparam int IW = idx_w(DATA_W);

    logic [IW-1:0] idx;

    // load starts a frame at bit 0 and wipes any stale upper bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            acc   <= 1'b0;
            idx   <= '0;
        end else if (load) begin
            shreg <= {{(DATA_W-1){1'b0}}, bit_in};
            acc   <= bit_in;
            idx   <= IW'(1);
        end else if (shift) begin
            shreg[idx] <= bit_in;
            acc        <= acc ^ bit_in;
            idx        <= idx + IW'(1);
        end
    end

    assign last = (idx == IW'(DATA_W - 1));

endmodule

// File: rtl/even_parity_checker.sv
// Serial even-parity receiver: deserialise DATA_W bits + parity, flag odd totals.
module even_parity_checker
    import parity_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_in,
    input  logic              bit_valid,
    input  logic              sof,
    input  logic              cnt_clr,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic              parity_err,
    output logic              frame_abort,
    output logic              busy,
    output logic [CNT_W-1:0]  err_count
);

    state_e             state_q, state_d;
    logic               load, shift, complete, abort;
    logic               acc, last, perr_d;
    logic [DATA_W-1:0]  shreg;
    logic [CNT_W-1:0]   cnt_d;

    parity_shift_accum #(.DATA_W(DATA_W)) u_sa (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .shift  (shift),
        .bit_in (bit_in),
        .shreg  (shreg),
        .acc    (acc),
        .last   (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // sof on any accepted beat restarts; mid-frame it also discards the frame
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        shift    = 1'b0;
        complete = 1'b0;
        abort    = 1'b0;
        if (bit_valid) begin
            if (sof) begin
                load    = 1'b1;
                abort   = (state_q != IDLE);
                state_d = DATA;
            end else begin
                case (state_q)
                    DATA: begin
                        shift = 1'b1;
                        if (last) state_d = PARITY;
                    end
                    PARITY: begin
                        complete = 1'b1;
                        state_d  = IDLE;
                    end
                    default: state_d = state_q;
                endcase
            end
        end
    end

    assign perr_d = acc ^ bit_in;

    // clear first, then count, so a coincident erroring frame lands at 1
    always_comb begin
        cnt_d = cnt_clr ? '0 : err_count;
        if (complete && perr_d && (cnt_d != {CNT_W{1'b1}}))
            cnt_d = cnt_d + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out    <= '0;
            out_valid   <= 1'b0;
            parity_err  <= 1'b0;
            frame_abort <= 1'b0;
            busy        <= 1'b0;
            err_count   <= '0;
        end else begin
            out_valid   <= complete;
            frame_abort <= abort;
            busy        <= (state_d != IDLE);
            err_count   <= cnt_d;
            if (complete) begin
                data_out   <= shreg;
                parity_err <= perr_d;
            end
        end
    end

endmodule
